uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial UART receive front end for the UART command processor: synchronises the `rx` pin, recovers 8N1 bytes with 16x oversampling and buffers them in a first-word-fall-through FIFO. The command processor drains the FIFO through its `rd_uart` / `rx_empty` / `r_data` interface and may flush it.

## Interface

**Parameters**
- `CLK_DIV`, default 27: `clk` cycles per oversample tick. Tick rate = 16 × baud.
- `FIFO_AW`, default 4: FIFO depth is 2^FIFO_AW entries.

**Ports**
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `rx`, input, 1: asynchronous serial line. Idles high.
- `rd_uart`, input, 1: pop strobe. Pops the head entry on the clock edge at which it is high.
- `flush`, input, 1: empties the FIFO. Driven by the command processor's `rx_fifo_flush_enable`.
- `r_data`, output, 8: head entry, combinational from FIFO memory. Valid whenever `rx_empty` = 0.
- `rx_empty`, output, 1: FIFO holds 0 entries.
- `rx_full`, output, 1: FIFO holds 2^FIFO_AW entries.
- `frame_err`, output, 1: one-cycle pulse. Stop bit sampled low.
- `overrun`, output, 1: one-cycle pulse. Received byte dropped because the FIFO was full.
- `parity_err`, output, 1: one-cycle pulse. Exists only with `UART_RX_PARITY_EN`.

## Operation

**Input synchroniser**
- Two-flop synchroniser on `rx`; both flops reset to 1.
- Everything downstream uses the synchronised signal `rxs`.

**Tick generator**
- Counter runs 0..CLK_DIV-1 and wraps.
- `tick` is high for one cycle when count = CLK_DIV-1.
- The counter free-runs; it is not aligned to the start bit.

**Receiver FSM**
- IDLE: on `rxs` = 0, go to START with tick count s = 0.
- START: on each tick, s++. When s = 7 (mid start bit):
  - `rxs` = 1: glitch; return to IDLE, no flag.
  - `rxs` = 0: go to DATA with s = 0, bit count n = 0.
- DATA: on each tick, s++. When s = 15:
  - Shift `rxs` into bit 7 of the shift register (right shift, LSB first).
  - s = 0, n++.
  - After the 8th bit, go to STOP (or PARITY when the macro is defined).
- STOP: when s = 15, sample `rxs`:
  - 1: push the byte.
  - 0: pulse `frame_err`, discard the byte.
  - In both cases return to IDLE.
- Push when FIFO full (and no simultaneous pop): byte dropped, `overrun` pulses, FIFO unchanged.

**FIFO**
- Write pointer, read pointer and count; count is FIFO_AW+1 bits wide.
- Pointers wrap modulo 2^FIFO_AW.
- `rd_uart` while empty is ignored; no pointer change.
- Push and pop in the same cycle: both take effect, count unchanged. This applies even when full, so no overrun.
- Push and pop in the same cycle while empty: push only.
- `flush`: pointers and count go to 0 on the next edge. Flush beats any simultaneous push or pop; a push in the same cycle is lost without an `overrun` pulse.

**Reset values**
- `rx_empty` = 1, `rx_full` = 0, `frame_err` = 0, `overrun` = 0, `parity_err` = 0.
- FSM in IDLE; tick counter 0.
- `r_data` is undefined while empty. FIFO memory is not reset.
- `rst` mid-frame abandons the frame; no push, no flag.

## Timing
- Push occurs on the clock edge of the tick at which the stop bit is sampled.
- `rx_empty` deasserts the following cycle.
- Pop is registered: `r_data` shows the next entry one cycle after the `rd_uart` edge.
- A consumer that samples `r_data` in the same cycle it asserts `rd_uart` gets the popped byte.
- Minimum start-bit width accepted: 8 ticks. Shorter pulses are rejected as glitches.
- Flags are registered and pulse in the cycle after the deciding edge.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- **Defined:** frame is 8E1.
  - A PARITY state follows DATA and samples the parity bit at s = 15.
  - Even-parity mismatch: pulse `parity_err` and discard the byte. The stop bit is still checked.
  - If both parity and stop bit fail, both flags pulse.
- **Undefined:** frame is 8N1; the `parity_err` port and the PARITY state are absent.

## Test plan
All scenarios use CLK_DIV = 4 and FIFO_AW = 2 (depth 4).

1. Send 0x57 ('W'), then 0x30 ('0'): `rx_empty` falls; `r_data` = 0x57; one `rd_uart` pulse gives `r_data` = 0x30; a second pulse gives `rx_empty` = 1.
2. Drive `rx` low for 5 ticks, then high: no push, no flags, FSM back in IDLE.
3. Send 0x41 with the stop bit low: `frame_err` pulses once, FIFO stays empty.
4. Send 5 bytes 0x01..0x05 with no reads: `rx_full` = 1 after 0x04, `overrun` pulses on 0x05, reads return 0x01..0x04.
5. FIFO full, and `rd_uart` asserted on the same edge as the push of 0x09: no `overrun`, count stays 4, last read returns 0x09.
6. Assert `flush` with 3 entries held and `rst` during a data bit: both give `rx_empty` = 1; the next clean frame 0x46 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Serial line and FIFO read port of the UART receive front end.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_fifo_if;
    logic       rx;
    logic       rd_uart;
    logic       flush;
    logic [7:0] r_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;

    modport slave (
        input  rx, rd_uart, flush,
        output r_data, rx_empty, rx_full, frame_err, overrun, parity_err
    );

    modport master (
        output rx, rd_uart, flush,
        input  r_data, rx_empty, rx_full, frame_err, overrun, parity_err
    );
`else
    modport slave (
        input  rx, rd_uart, flush,
        output r_data, rx_empty, rx_full, frame_err, overrun
    );

    modport master (
        output rx, rd_uart, flush,
        input  r_data, rx_empty, rx_full, frame_err, overrun
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampling, 8N1) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx_fifo #(
    parameter int unsigned CLK_DIV = 27,
    parameter int unsigned FIFO_AW = 4
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP
    } state_t;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rxs     <= rx_meta;
        end
    end

    // Free-running oversample tick, 16 per bit
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_MAX);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    state_t     state, state_nxt;
    logic [3:0] s, s_nxt;
    logic [2:0] n, n_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       push;
    logic       frame_bad;
`ifdef UART_RX_PARITY_EN
    logic       par_bad, par_bad_nxt;
    logic       parity_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            s     <= '0;
            n     <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            n     <= n_nxt;
            shreg <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        n_nxt     = n;
        shreg_nxt = shreg;
        push      = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        parity_bad  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_nxt = ST_START;
                    s_nxt     = '0;
                end
            end
            // Re-check the line mid start bit to reject short glitches
            ST_START: begin
                if (tick) begin
                    if (s == 4'd7) begin
                        if (rxs) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_DATA;
                            s_nxt     = '0;
                            n_nxt     = '0;
                        end
                    end else begin
                        s_nxt = s + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        s_nxt     = '0;
                        shreg_nxt = {rxs, shreg[7:1]};
                        n_nxt     = n + 3'd1;
                        if (n == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            state_nxt = ST_STOP;
`endif
                        end
                    end else begin
                        s_nxt = s + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero
            ST_PARITY: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        s_nxt       = '0;
                        par_bad_nxt = ^{shreg, rxs};
                        parity_bad  = ^{shreg, rxs};
                        state_nxt   = ST_STOP;
                    end else begin
                        s_nxt = s + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (s == 4'd15) begin
                        state_nxt = ST_IDLE;
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            push = !par_bad;
`else
                            push = 1'b1;
`endif
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else begin
                        s_nxt = s + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FIFO: a pop frees the slot in the same edge, so push+pop when full is legal
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               empty_c;
    logic               full_c;
    logic               do_pop;
    logic               do_push;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_FULL);
    assign do_pop  = bus.rd_uart && !empty_c;
    assign do_push = push && (!full_c || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !bus.flush) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Status pulses; a flushed push is silently lost
    logic frame_err_q;
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            overrun_q   <= push && full_c && !do_pop && !bus.flush;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_bad;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

    assign bus.r_data    = mem[rd_ptr];
    assign bus.rx_empty  = empty_c;
    assign bus.rx_full   = full_c;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLK_DIV=4, FIFO depth 4: table of frames
// plus hand sequences for glitch, overrun, push/pop-when-full, flush and reset.
module tb_uart_rx_fifo;
    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned FIFO_AW  = 2;
    localparam int          BIT_CLKS = 16 * CLK_DIV;
    localparam int          NVEC     = 7;

    logic clk = 1'b0;
    logic rst;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .CLK_DIV(CLK_DIV),
        .FIFO_AW(FIFO_AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int unsigned cyc = 0;

    always @(negedge clk) begin
        if (bus.frame_err) fe_cnt++;
        if (bus.overrun) ov_cnt++;
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_fe;
        logic       exp_empty;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    // Bad stop bits are held low only 3/4 of a bit so the line is high again
    // before the receiver re-checks the start bit it then sees.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        bus.rx = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            wait_clk(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = ^d;
        wait_clk(BIT_CLKS);
`endif
        bus.rx = stop_bit;
        if (stop_bit) begin
            wait_clk(BIT_CLKS);
        end else begin
            wait_clk(BIT_CLKS * 3 / 4);
            bus.rx = 1'b1;
            wait_clk(BIT_CLKS / 4);
        end
        bus.rx = 1'b1;
    endtask

    task automatic send_idle(input logic [7:0] d, input logic stop_bit);
        send_frame(d, stop_bit);
        wait_clk(BIT_CLKS);
    endtask

    task automatic align();
        for (int i = 0; i < 8 && (cyc % CLK_DIV) != 0; i++) wait_clk(1);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check(name, bus.r_data, exp);
        bus.rd_uart = 1'b1;
        wait_clk(1);
        bus.rd_uart = 1'b0;
    endtask

    int fe0;
    int ov0;
    int lat;

    initial begin
        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_fe: 0, exp_empty: 1'b0};
        vecs[1] = '{data: 8'h41, stop_bit: 1'b0, exp_fe: 1, exp_empty: 1'b1};
        vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_fe: 0, exp_empty: 1'b0};
        vecs[3] = '{data: 8'hFF, stop_bit: 1'b1, exp_fe: 0, exp_empty: 1'b0};
        vecs[4] = '{data: 8'h80, stop_bit: 1'b0, exp_fe: 1, exp_empty: 1'b1};
        vecs[5] = '{data: 8'h3C, stop_bit: 1'b1, exp_fe: 0, exp_empty: 1'b0};
        vecs[6] = '{data: 8'h01, stop_bit: 1'b1, exp_fe: 0, exp_empty: 1'b0};

        rst         = 1'b1;
        bus.rx      = 1'b1;
        bus.rd_uart = 1'b0;
        bus.flush   = 1'b0;
        wait_clk(3);
        check("reset_rx_empty", bus.rx_empty, 1);
        check("reset_rx_full", bus.rx_full, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_overrun", bus.overrun, 0);
        rst = 1'b0;
        wait_clk(5);

        // Two back-to-back frames, FWFT reads, pop on empty ignored
        send_frame(8'h57, 1'b1);
        send_idle(8'h30, 1'b1);
        check("t1_not_empty", bus.rx_empty, 0);
        pop_expect("t1_head_57", 8'h57);
        pop_expect("t1_head_30", 8'h30);
        check("t1_empty", bus.rx_empty, 1);
        bus.rd_uart = 1'b1;
        wait_clk(1);
        bus.rd_uart = 1'b0;
        check("t1_pop_on_empty", bus.rx_empty, 1);

        // Start-bit glitch of 5 ticks
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        bus.rx = 1'b0;
        wait_clk(5 * CLK_DIV);
        bus.rx = 1'b1;
        wait_clk(2 * BIT_CLKS);
        check("t2_glitch_empty", bus.rx_empty, 1);
        check("t2_glitch_fe", fe_cnt - fe0, 0);
        check("t2_glitch_ov", ov_cnt - ov0, 0);

        for (int i = 0; i < NVEC; i++) begin
            fe0 = fe_cnt;
            send_idle(vecs[i].data, vecs[i].stop_bit);
            check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_rx_empty", i), bus.rx_empty, vecs[i].exp_empty);
            if (!vecs[i].exp_empty) begin
                pop_expect($sformatf("vec%0d_r_data", i), vecs[i].data);
                check($sformatf("vec%0d_drained", i), bus.rx_empty, 1);
            end
        end

        // Fill past depth: fifth byte overruns
        ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_idle(8'(i), 1'b1);
            check($sformatf("t4_full_after_%0d", i), bus.rx_full, (i == 4) ? 1 : 0);
        end
        check("t4_no_overrun_yet", ov_cnt - ov0, 0);
        send_idle(8'h05, 1'b1);
        check("t4_overrun", ov_cnt - ov0, 1);
        check("t4_still_full", bus.rx_full, 1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("t4_read_%0d", i), 8'(i));
        check("t4_empty", bus.rx_empty, 1);

        // Measure frame-start to push latency on an aligned tick phase
        align();
        fork
            send_idle(8'h05, 1'b1);
            begin
                lat = 0;
                while (bus.rx_empty && lat < 2000) begin
                    wait_clk(1);
                    lat++;
                end
            end
        join
        check("t5_push_latency", lat, 608);
        send_idle(8'h06, 1'b1);
        send_idle(8'h07, 1'b1);
        send_idle(8'h08, 1'b1);
        check("t5_full", bus.rx_full, 1);
        ov0 = ov_cnt;
        align();
        fork
            send_idle(8'h09, 1'b1);
            begin
                wait_clk(lat - 1);
                bus.rd_uart = 1'b1;
                wait_clk(1);
                bus.rd_uart = 1'b0;
            end
        join
        check("t5_no_overrun", ov_cnt - ov0, 0);
        check("t5_still_full", bus.rx_full, 1);
        pop_expect("t5_read_06", 8'h06);
        pop_expect("t5_read_07", 8'h07);
        pop_expect("t5_read_08", 8'h08);
        pop_expect("t5_read_09", 8'h09);
        check("t5_empty", bus.rx_empty, 1);

        // Flush with three entries held
        send_idle(8'h11, 1'b1);
        send_idle(8'h22, 1'b1);
        send_idle(8'h33, 1'b1);
        check("t6_held_not_empty", bus.rx_empty, 0);
        check("t6_held_not_full", bus.rx_full, 0);
        bus.flush = 1'b1;
        wait_clk(1);
        bus.flush = 1'b0;
        check("t6_flush_empty", bus.rx_empty, 1);

        // Reset in the middle of data bit 1
        fe0 = fe_cnt;
        bus.rx = 1'b0;
        wait_clk(BIT_CLKS);
        bus.rx = 1'b1;
        wait_clk(BIT_CLKS);
        bus.rx = 1'b0;
        wait_clk(BIT_CLKS / 2);
        rst    = 1'b1;
        bus.rx = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(2 * BIT_CLKS);
        check("t6_rst_empty", bus.rx_empty, 1);
        check("t6_rst_no_fe", fe_cnt - fe0, 0);
        send_idle(8'h46, 1'b1);
        check("t6_after_not_empty", bus.rx_empty, 0);
        pop_expect("t6_read_46", 8'h46);
        check("t6_final_empty", bus.rx_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
